// File: rtl/xcel_bram_read_responder.sv
// Byte-read responder for a compute unit: a one-word line buffer in front of a
// 32-bit synchronous RAM, with saturating hit/miss counters.
`timescale 1ns/1ps
module xcel_bram_read_responder #(
   parameter int AWIDTH = 10,
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       req_addr,
   input  logic              req_ready,
   output logic [DWIDTH-1:0] rsp_data,
   output logic              rsp_valid,
   output logic [AWIDTH-1:0] mem_addr,
   output logic              mem_en,
   input  logic [31:0]       mem_q,
   input  logic              inv,
   input  logic              cnt_clr,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
);

   typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, RESP} state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_line_valid;
   logic [AWIDTH-1:0]   r_tag;
   logic [AWIDTH-1:0]   r_req_tag;
   logic [1:0]          r_sel;
   logic [31:0]         r_word;
   logic [DWIDTH-1:0]   r_rsp_data;
   logic [31:0]         r_hit_cnt;
   logic [31:0]         r_miss_cnt;

   logic [AWIDTH-1:0]   w_req_tag;
   logic                w_sample;
   logic                w_hit;
   logic                w_miss;
   logic [DWIDTH-1:0]   w_hit_byte;
   logic [DWIDTH-1:0]   w_cap_byte;
   logic                w_unused_addr;

   // Upper address bits wrap away: only the low AWIDTH word-address bits matter.
   assign w_req_tag     = req_addr[AWIDTH+1:2];
   assign w_unused_addr = ^req_addr[31:AWIDTH+2];

   assign w_sample   = (r_state == IDLE) && req_ready;
   assign w_hit      = w_sample && r_line_valid && (r_tag == w_req_tag) && !inv;
   assign w_miss     = w_sample && !w_hit;
   assign w_hit_byte = r_word[{req_addr[1:0], 3'b000} +: DWIDTH];
   assign w_cap_byte = r_word[{r_sel, 3'b000} +: DWIDTH];

   // RAM strobe is combinational from the lookup, so it is gated by reset directly.
   assign mem_en    = w_miss && rst_n;
   assign mem_addr  = mem_en ? w_req_tag : '0;
   assign rsp_valid = (r_state == RESP);
   assign rsp_data  = r_rsp_data;
   assign hit_cnt   = r_hit_cnt;
   assign miss_cnt  = r_miss_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_hit)       w_next = RESP;
            else if (w_miss) w_next = FETCH;
         end
         FETCH:   w_next = CAPTURE;
         CAPTURE: w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_line_valid <= 1'b0;
         r_tag        <= '0;
         r_req_tag    <= '0;
         r_sel        <= '0;
         r_word       <= '0;
         r_rsp_data   <= '0;
      end else begin
         if (w_sample) begin
            r_req_tag <= w_req_tag;
            r_sel     <= req_addr[1:0];
         end
         if (w_hit) r_rsp_data <= w_hit_byte;
         if (r_state == FETCH) begin
            r_word <= mem_q;
            r_tag  <= r_req_tag;
         end
         if (r_state == CAPTURE) r_rsp_data <= w_cap_byte;
         // An invalidate anywhere, including mid-fill, leaves the line invalid.
         if (inv)                    r_line_valid <= 1'b0;
         else if (r_state == FETCH)  r_line_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (cnt_clr) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_hit  && (r_hit_cnt  != '1)) r_hit_cnt  <= r_hit_cnt + 32'd1;
         if (w_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_xcel_bram_read_responder.sv
// Directed bench: table of single requests plus hand-written sequences for
// counter clear/saturation, mid-operation reset and a streaming sweep.
`timescale 1ns/1ps
module tb_xcel_bram_read_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] req_addr = '0;
   logic        req_ready = 1'b0;
   logic [7:0]  rsp_data;
   logic        rsp_valid;
   logic [9:0]  mem_addr;
   logic        mem_en;
   logic [31:0] mem_q = '0;
   logic        inv = 1'b0;
   logic        cnt_clr = 1'b0;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   int checks = 0;
   int errors = 0;
   int stray_en = 0;

   xcel_bram_read_responder #(.AWIDTH(10), .DWIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_ready(req_ready),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .mem_addr(mem_addr),
      .mem_en(mem_en), .mem_q(mem_q), .inv(inv), .cnt_clr(cnt_clr),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   // RAM content: byte at byte address a is (a + 8'h7E) mod 256, so word 0 = 32'h8180_7F7E.
   function automatic logic [7:0] exp_byte(input logic [31:0] a);
      return 8'(a + 32'h7E);
   endfunction

   always @(posedge clk)
      if (mem_en)
         mem_q <= {exp_byte({20'b0, mem_addr, 2'd3}), exp_byte({20'b0, mem_addr, 2'd2}),
                   exp_byte({20'b0, mem_addr, 2'd1}), exp_byte({20'b0, mem_addr, 2'd0})};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One request; inv_cyc selects the cycle with inv high (0 = lookup cycle, 1 = FETCH, 2 = CAPTURE).
   task automatic do_req(input logic [31:0] a, input int inv_cyc, input logic clr,
                         output logic [7:0] d, output int lat, output logic en, output logic [9:0] ma);
      @(negedge clk);
      req_addr = a; req_ready = 1'b1; inv = (inv_cyc == 0); cnt_clr = clr;
      #1;
      en = mem_en; ma = mem_addr;
      @(posedge clk);
      #1;
      inv = 1'b0; cnt_clr = 1'b0; req_addr = ~a;
      lat = 99; d = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = c; d = rsp_data; req_ready = 1'b0; inv = 1'b0;
            break;
         end
         if (mem_en) stray_en++;
         inv = (inv_cyc == c);
      end
      req_ready = 1'b0; inv = 1'b0;
   endtask

   typedef struct {
      logic [31:0] addr;
      int          inv_cyc;
      logic        hit;
      logic [7:0]  data;
      logic [9:0]  maddr;
   } vec_t;

   vec_t tbl[14];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin : main
      logic [7:0] d;
      int         lat;
      logic       en;
      logic [9:0] ma;
      int         serr;
      int         pulses;

      tbl[0]  = '{32'h0000_0000, -1, 1'b0, 8'h7E, 10'h000};
      tbl[1]  = '{32'h0000_0003, -1, 1'b1, 8'h81, 10'h000};
      tbl[2]  = '{32'h0000_0001, -1, 1'b1, 8'h7F, 10'h000};
      tbl[3]  = '{32'h0000_0005, -1, 1'b0, 8'h83, 10'h001};
      tbl[4]  = '{32'h0000_0006,  0, 1'b0, 8'h84, 10'h001};
      tbl[5]  = '{32'h0000_1008, -1, 1'b0, 8'h86, 10'h002};
      tbl[6]  = '{32'h0000_000A, -1, 1'b1, 8'h88, 10'h000};
      tbl[7]  = '{32'hFFFF_FFFF, -1, 1'b0, 8'h7D, 10'h3FF};
      tbl[8]  = '{32'h0000_0FFC, -1, 1'b1, 8'h7A, 10'h000};
      tbl[9]  = '{32'h0000_0014,  1, 1'b0, 8'h92, 10'h005};
      tbl[10] = '{32'h0000_0015, -1, 1'b0, 8'h93, 10'h005};
      tbl[11] = '{32'h0000_0016, -1, 1'b1, 8'h94, 10'h000};
      tbl[12] = '{32'h0000_0018,  2, 1'b0, 8'h96, 10'h006};
      tbl[13] = '{32'h0000_0019, -1, 1'b0, 8'h97, 10'h006};

      // Reset with a request pending: outputs must stay at reset values.
      req_ready = 1'b1; req_addr = 32'h5;
      #12;
      chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset_rsp_data", {24'b0, rsp_data}, 32'd0);
      chk("reset_mem_en", {31'b0, mem_en}, 32'd0);
      chk("reset_mem_addr", {22'b0, mem_addr}, 32'd0);
      chk("reset_hit_cnt", hit_cnt, 32'd0);
      chk("reset_miss_cnt", miss_cnt, 32'd0);
      req_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         do_req(tbl[i].addr, tbl[i].inv_cyc, 1'b0, d, lat, en, ma);
         chk($sformatf("vec%0d_data", i), {24'b0, d}, {24'b0, tbl[i].data});
         chk($sformatf("vec%0d_latency", i), lat, tbl[i].hit ? 32'd1 : 32'd3);
         chk($sformatf("vec%0d_mem_en", i), {31'b0, en}, {31'b0, !tbl[i].hit});
         if (!tbl[i].hit)
            chk($sformatf("vec%0d_mem_addr", i), {22'b0, ma}, {22'b0, tbl[i].maddr});
      end
      chk("table_hit_cnt", hit_cnt, 32'd5);
      chk("table_miss_cnt", miss_cnt, 32'd9);

      // Clear coincident with a hit: clear wins.
      do_req(32'h1A, -1, 1'b1, d, lat, en, ma);
      chk("clr_hit_data", {24'b0, d}, 32'h98);
      chk("clr_hit_latency", lat, 32'd1);
      chk("clr_hit_cnt", hit_cnt, 32'd0);
      chk("clr_miss_cnt", miss_cnt, 32'd0);

      // Saturation: preload the hit counter at all-ones, then hit.
      @(negedge clk);
      force dut.r_hit_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_hit_cnt;
      do_req(32'h1B, -1, 1'b0, d, lat, en, ma);
      chk("sat_hit_data", {24'b0, d}, 32'h99);
      chk("sat_hit_cnt", hit_cnt, 32'hFFFF_FFFF);
      chk("sat_miss_cnt", miss_cnt, 32'd0);

      // Reset for half a cycle while the miss is in CAPTURE.
      @(negedge clk);
      req_addr = 32'h28; req_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("midrst_rsp_data", {24'b0, rsp_data}, 32'd0);
      chk("midrst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("midrst_mem_addr", {22'b0, mem_addr}, 32'd0);
      chk("midrst_hit_cnt", hit_cnt, 32'd0);
      #3;
      rst_n = 1'b1;
      req_ready = 1'b0;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      chk("midrst_no_rsp_valid", pulses, 32'd0);
      do_req(32'h28, -1, 1'b0, d, lat, en, ma);
      chk("postrst_data", {24'b0, d}, 32'hA6);
      chk("postrst_latency", lat, 32'd3);
      chk("postrst_miss_cnt", miss_cnt, 32'd1);
      chk("postrst_hit_cnt", hit_cnt, 32'd0);

      // Streaming sweep over 1568 sequential bytes.
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      serr = 0;
      for (int a = 0; a < 1568; a++) begin
         do_req(32'(a), -1, 1'b0, d, lat, en, ma);
         if (d !== exp_byte(32'(a))) serr++;
      end
      chk("stream_byte_errors", serr, 32'd0);
      chk("stream_miss_cnt", miss_cnt, 32'd392);
      chk("stream_hit_cnt", hit_cnt, 32'd1176);
      chk("mem_en_outside_lookup", stray_en, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
